// File: rtl/srisc_core_if.sv
// Memory bus between the srisc core and the RAM/IO fabric.
// mem_ready completes a read or write on the clock edge where it is sampled high.
interface srisc_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (input mem_rdata, mem_ready, output mem_cmd, mem_addr, mem_wdata);
  modport slave  (output mem_rdata, mem_ready, input mem_cmd, mem_addr, mem_wdata);
endinterface

// File: rtl/srisc_core.sv
// Multicycle Simple RISC Machine core with parametrised data/address widths.
// Owns register file, ALU, shifter, PC, IR and the control FSM.
module srisc_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  srisc_core_if.master mem,
  output logic         n_o,
  output logic         v_o,
  output logic         z_o,
  output logic         halted_o
);
  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [15:0]       ir_q, ir_d;
  logic              n_q, n_d, v_q, v_d, z_q, z_d;
  logic [DATA_W-1:0] regs_q [8];

  logic              regWe;
  logic [2:0]        regWaddr;
  logic [DATA_W-1:0] regWdata;

  logic [2:0]        opcode, rnIdx, rdIdx, rmIdx;
  logic [1:0]        op, sh;
  logic [DATA_W-1:0] rnVal, rdVal, rmVal, shVal, sumVal, diffVal, sximm8, sximm5, pcExt;
  logic [ADDR_W-1:0] pcBranch, memAddr;
  logic              condTrue;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rnIdx  = ir_q[10:8];
  assign rdIdx  = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rmIdx  = ir_q[2:0];

  assign rnVal   = regs_q[rnIdx];
  assign rdVal   = regs_q[rdIdx];
  assign rmVal   = regs_q[rmIdx];
  assign sximm8  = DATA_W'($signed(ir_q[7:0]));
  assign sximm5  = DATA_W'($signed(ir_q[4:0]));
  assign pcExt   = DATA_W'(pc_q);
  assign sumVal  = rnVal + shVal;
  assign diffVal = rnVal - shVal;
  // Branch targets use the PC already incremented by FETCH and wrap at 2^ADDR_W.
  assign pcBranch = pc_q + ADDR_W'($signed(ir_q[7:0]));
  assign memAddr  = ADDR_W'(rnVal + sximm5);

  always_comb begin
    shVal = rmVal;
    case (sh)
      2'b01:   shVal = {rmVal[DATA_W-2:0], 1'b0};
      2'b10:   shVal = {1'b0, rmVal[DATA_W-1:1]};
      2'b11:   shVal = {rmVal[DATA_W-1], rmVal[DATA_W-1:1]};
      default: shVal = rmVal;
    endcase
  end

  always_comb begin
    case (rnIdx)
      3'b000:  condTrue = 1'b1;
      3'b001:  condTrue = z_q;
      3'b010:  condTrue = ~z_q;
      3'b011:  condTrue = n_q ^ v_q;
      3'b100:  condTrue = (n_q ^ v_q) | z_q;
      default: condTrue = 1'b0;
    endcase
  end

  // All operand reads are combinational from the current registers, so BLX R7
  // picks up the old R7 before the link write lands at the same edge.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    n_d      = n_q;
    v_d      = v_q;
    z_d      = z_q;
    regWe    = 1'b0;
    regWaddr = rdIdx;
    regWdata = sumVal;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata[15:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          3'b110: begin
            if (op == 2'b10) begin
              regWe = 1'b1; regWaddr = rnIdx; regWdata = sximm8;
            end else if (op == 2'b00) begin
              regWe = 1'b1; regWdata = shVal;
            end
          end
          3'b101: begin
            case (op)
              2'b00: begin regWe = 1'b1; regWdata = sumVal; end
              2'b01: begin
                z_d = (diffVal == '0);
                n_d = diffVal[DATA_W-1];
                v_d = (rnVal[DATA_W-1] ^ shVal[DATA_W-1]) & (diffVal[DATA_W-1] ^ rnVal[DATA_W-1]);
              end
              2'b10:   begin regWe = 1'b1; regWdata = rnVal & shVal; end
              default: begin regWe = 1'b1; regWdata = ~shVal; end
            endcase
          end
          3'b011, 3'b100: begin
            if (op == 2'b00) begin
              addr_d  = memAddr;
              state_d = S_MEM;
            end
          end
          3'b001: if (op == 2'b00 && condTrue) pc_d = pcBranch;
          3'b010: begin
            case (op)
              2'b11: begin regWe = 1'b1; regWaddr = 3'd7; regWdata = pcExt; pc_d = pcBranch; end
              2'b00: pc_d = ADDR_W'(rdVal);
              2'b10: begin regWe = 1'b1; regWaddr = 3'd7; regWdata = pcExt; pc_d = ADDR_W'(rdVal); end
              default: ;
            endcase
          end
          3'b111:  state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ready) begin
          state_d = S_FETCH;
          if (opcode == 3'b011) begin
            regWe = 1'b1; regWdata = mem.mem_rdata;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      addr_q  <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      if (regWe) regs_q[regWaddr] <= regWdata;
    end
  end

  // Bus outputs decode purely from state and registers so they stay stable across waits.
  always_comb begin
    mem.mem_cmd   = 2'b00;
    mem.mem_addr  = pc_q;
    mem.mem_wdata = '0;
    if (state_q == S_FETCH) begin
      mem.mem_cmd = 2'b01;
    end else if (state_q == S_MEM) begin
      mem.mem_addr = addr_q;
      if (opcode == 3'b011) begin
        mem.mem_cmd = 2'b01;
      end else begin
        mem.mem_cmd   = 2'b10;
        mem.mem_wdata = rdVal;
      end
    end
  end

  assign n_o      = n_q;
  assign v_o      = v_q;
  assign z_o      = z_q;
  assign halted_o = (state_q == S_HALT);
endmodule

// File: tb/tb_srisc_core.sv
// Directed-vector bench for srisc_core: a 16/9 core with a wait-state memory
// model and a 32/4 core starting at PC 13 for the wide-data and PC-wrap cases.
module tb_srisc_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0, reset1, clear0, stallWrites0;
  int   waitStates0, waitCnt0;
  logic halted0, halted1, n0, v0, z0, n1, v1, z1;

  logic [15:0] image0 [512];
  logic [15:0] mem0   [512];
  logic [31:0] image1 [16];
  logic [31:0] mem1   [16];

  int         writes0, wrCycles0, ld7Cycles0, badWdata0;
  logic [8:0] lastWrAddr0;
  logic [8:0] readLog0 [$];
  logic [3:0] readLog1 [$];

  int vectorsApplied = 0;
  int miscompares = 0;

  srisc_core_if #(.DATA_W(16), .ADDR_W(9)) bus0 ();
  srisc_core_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

  srisc_core #(.DATA_W(16), .ADDR_W(9), .RESET_PC(9'd0)) dut0 (
    .clk(clk), .reset(reset0), .mem(bus0.master),
    .n_o(n0), .v_o(v0), .z_o(z0), .halted_o(halted0)
  );

  srisc_core #(.DATA_W(32), .ADDR_W(4), .RESET_PC(4'd13)) dut1 (
    .clk(clk), .reset(reset1), .mem(bus1.master),
    .n_o(n1), .v_o(v1), .z_o(z1), .halted_o(halted1)
  );

  // Memory model: waitStates0 low cycles before ready, optional stall of writes.
  assign bus0.mem_rdata = mem0[bus0.mem_addr];
  assign bus0.mem_ready = (waitStates0 == 0) ? 1'b1 :
                          ((stallWrites0 && bus0.mem_cmd == 2'b10) ? 1'b0 : (waitCnt0 >= waitStates0));
  assign bus1.mem_rdata = mem1[bus1.mem_addr];
  assign bus1.mem_ready = 1'b1;

  always @(posedge clk) begin
    if (clear0) begin
      mem0        <= image0;
      writes0     <= 0;
      wrCycles0   <= 0;
      ld7Cycles0  <= 0;
      badWdata0   <= 0;
      lastWrAddr0 <= '0;
      waitCnt0    <= 0;
      readLog0.delete();
    end else begin
      if (bus0.mem_cmd == 2'b00 || bus0.mem_ready) waitCnt0 <= 0;
      else waitCnt0 <= waitCnt0 + 1;
      if (bus0.mem_cmd == 2'b10) begin
        wrCycles0 <= wrCycles0 + 1;
        if (bus0.mem_ready) begin
          mem0[bus0.mem_addr] <= bus0.mem_wdata;
          writes0             <= writes0 + 1;
          lastWrAddr0         <= bus0.mem_addr;
        end
      end
      if (bus0.mem_cmd == 2'b01 && bus0.mem_addr == 9'd7) ld7Cycles0 <= ld7Cycles0 + 1;
      if (bus0.mem_cmd != 2'b10 && bus0.mem_wdata != 16'h0000) badWdata0 <= badWdata0 + 1;
      if (bus0.mem_cmd == 2'b01 && bus0.mem_ready) readLog0.push_back(bus0.mem_addr);
    end
  end

  always @(posedge clk) begin
    if (reset1) begin
      mem1 <= image1;
      readLog1.delete();
    end else if (bus1.mem_cmd == 2'b01) begin
      readLog1.push_back(bus1.mem_addr);
    end
  end

  function automatic logic [15:0] movi(input logic [2:0] rn, input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction
  function automatic logic [15:0] movr(input logic [2:0] rd, input logic [1:0] s, input logic [2:0] rm);
    return {3'b110, 2'b00, 3'b000, rd, s, rm};
  endfunction
  function automatic logic [15:0] alu(input logic [1:0] o, input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [1:0] s, input logic [2:0] rm);
    return {3'b101, o, rn, rd, s, rm};
  endfunction
  function automatic logic [15:0] bcond(input logic [2:0] c, input logic [7:0] imm);
    return {3'b001, 2'b00, c, imm};
  endfunction
  function automatic logic [15:0] bxop(input logic [1:0] o, input logic [2:0] rd);
    return {3'b010, o, 3'b000, rd, 5'b00000};
  endfunction

  localparam logic [15:0] HALT = 16'hE000;

  task automatic clearImage0;
    foreach (image0[i]) image0[i] = 16'h0000;
  endtask

  task automatic doReset0;
    @(negedge clk);
    reset0 = 1'b1; clear0 = 1'b1;
    repeat (2) @(negedge clk);
    reset0 = 1'b0; clear0 = 1'b0;
  endtask

  task automatic runUntilHalt(input int which, input int limit, output int cycles);
    cycles = 0;
    while (((which == 0) ? halted0 : halted1) !== 1'b1 && cycles < limit) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset0 = 1'b1; clear0 = 1'b1; reset1 = 1'b1;
    repeat (2) @(posedge clk); #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_cmd: got %b want 00", bus0.mem_cmd); end
    vectorsApplied++; if (bus0.mem_addr !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %0d want 0", bus0.mem_addr); end
    vectorsApplied++; if (bus0.mem_wdata !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_wdata: got %h want 0", bus0.mem_wdata); end
    vectorsApplied++; if ({halted0, n0, v0, z0} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_status: got %b want 0000", {halted0, n0, v0, z0}); end
    vectorsApplied++; if (dut0.regs_q[3] !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_r3: got %h want 0", dut0.regs_q[3]); end
    vectorsApplied++; if (bus1.mem_addr !== 4'd13) begin miscompares++; $display("[TB] FAIL reset_pc_wide: got %0d want 13", bus1.mem_addr); end
    @(negedge clk);
    reset0 = 1'b0; clear0 = 1'b0; reset1 = 1'b0;
    #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_state_cmd: got %b want 00", bus0.mem_cmd); end
    @(posedge clk); #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b01 || bus0.mem_addr !== 9'd0) begin miscompares++; $display("[TB] FAIL first_fetch: got cmd %b addr %0d want 01/0", bus0.mem_cmd, bus0.mem_addr); end
    vectorsApplied++; if (bus1.mem_cmd !== 2'b01 || bus1.mem_addr !== 4'd13) begin miscompares++; $display("[TB] FAIL first_fetch_wide: got cmd %b addr %0d want 01/13", bus1.mem_cmd, bus1.mem_addr); end
  endtask

  task automatic test_alu_program;
    int cycles;
    clearImage0();
    waitStates0 = 0;
    image0[0] = movi(3'd0, 8'd5);
    image0[1] = movi(3'd1, 8'hFD);
    image0[2] = alu(2'b00, 3'd0, 3'd2, 2'b00, 3'd1);
    image0[3] = HALT;
    doReset0();
    runUntilHalt(0, 50, cycles);
    vectorsApplied++; if (cycles !== 9 || halted0 !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_cycle: got %0d (halted %b) want 9", cycles, halted0); end
    vectorsApplied++; if (dut0.regs_q[2] !== 16'h0002) begin miscompares++; $display("[TB] FAIL add_r2: got %h want 0002", dut0.regs_q[2]); end
    vectorsApplied++; if (dut0.regs_q[1] !== 16'hFFFD) begin miscompares++; $display("[TB] FAIL mov_neg_r1: got %h want fffd", dut0.regs_q[1]); end
    vectorsApplied++; if ({n0, v0, z0} !== 3'b000) begin miscompares++; $display("[TB] FAIL alu_flags: got %b want 000", {n0, v0, z0}); end
    @(posedge clk); #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b00 || halted0 !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_hold: got cmd %b halted %b want 00/1", bus0.mem_cmd, halted0); end
  endtask

  task automatic test_branch_lt;
    int cycles;
    clearImage0();
    image0[0] = movi(3'd0, 8'd1);
    image0[1] = movi(3'd1, 8'd2);
    image0[2] = alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd1);
    image0[3] = bcond(3'b011, 8'd1);
    image0[4] = movi(3'd3, 8'd7);
    image0[5] = movi(3'd4, 8'd9);
    image0[6] = HALT;
    doReset0();
    runUntilHalt(0, 100, cycles);
    vectorsApplied++; if ({n0, v0, z0} !== 3'b100) begin miscompares++; $display("[TB] FAIL cmp_lt_flags: got %b want 100", {n0, v0, z0}); end
    vectorsApplied++; if (dut0.regs_q[3] !== 16'h0000) begin miscompares++; $display("[TB] FAIL blt_skip_r3: got %h want 0000", dut0.regs_q[3]); end
    vectorsApplied++; if (dut0.regs_q[4] !== 16'h0009) begin miscompares++; $display("[TB] FAIL blt_target_r4: got %h want 0009", dut0.regs_q[4]); end
  endtask

  task automatic test_cond_logic;
    int cycles;
    clearImage0();
    image0[0] = movi(3'd0, 8'd3);
    image0[1] = alu(2'b01, 3'd0, 3'd0, 2'b00, 3'd0);
    image0[2] = bcond(3'b010, 8'd1);
    image0[3] = movi(3'd5, 8'd1);
    image0[4] = bcond(3'b001, 8'd1);
    image0[5] = movi(3'd6, 8'd1);
    image0[6] = alu(2'b10, 3'd0, 3'd3, 2'b01, 3'd5);
    image0[7] = alu(2'b11, 3'd0, 3'd4, 2'b11, 3'd0);
    image0[8] = HALT;
    doReset0();
    runUntilHalt(0, 100, cycles);
    vectorsApplied++; if ({n0, v0, z0} !== 3'b001) begin miscompares++; $display("[TB] FAIL cmp_eq_flags: got %b want 001", {n0, v0, z0}); end
    vectorsApplied++; if (dut0.regs_q[5] !== 16'h0001) begin miscompares++; $display("[TB] FAIL bne_not_taken: got %h want 0001", dut0.regs_q[5]); end
    vectorsApplied++; if (dut0.regs_q[6] !== 16'h0000) begin miscompares++; $display("[TB] FAIL beq_taken: got %h want 0000", dut0.regs_q[6]); end
    vectorsApplied++; if (dut0.regs_q[3] !== 16'h0002) begin miscompares++; $display("[TB] FAIL and_lsl: got %h want 0002", dut0.regs_q[3]); end
    vectorsApplied++; if (dut0.regs_q[4] !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL mvn_asr: got %h want fffe", dut0.regs_q[4]); end
  endtask

  task automatic test_mem_waits;
    int cycles;
    clearImage0();
    waitStates0 = 2;
    image0[0] = movi(3'd0, 8'h12);
    for (int i = 1; i <= 8; i++) image0[i] = movr(3'd0, 2'b01, 3'd0);
    image0[9]  = movi(3'd3, 8'h34);
    image0[10] = alu(2'b00, 3'd0, 3'd0, 2'b00, 3'd3);
    image0[11] = movi(3'd1, 8'd4);
    image0[12] = {3'b100, 2'b00, 3'd1, 3'd0, 5'd3};
    image0[13] = {3'b011, 2'b00, 3'd1, 3'd2, 5'd3};
    image0[14] = HALT;
    doReset0();
    runUntilHalt(0, 400, cycles);
    vectorsApplied++; if (halted0 !== 1'b1) begin miscompares++; $display("[TB] FAIL mem_halt_timeout: got halted %b want 1", halted0); end
    vectorsApplied++; if (writes0 !== 1 || lastWrAddr0 !== 9'd7) begin miscompares++; $display("[TB] FAIL str_writes: got %0d at %0d want 1 at 7", writes0, lastWrAddr0); end
    vectorsApplied++; if (mem0[7] !== 16'h1234) begin miscompares++; $display("[TB] FAIL str_data: got %h want 1234", mem0[7]); end
    vectorsApplied++; if (wrCycles0 !== 3) begin miscompares++; $display("[TB] FAIL str_length: got %0d want 3", wrCycles0); end
    // Address 7 is read twice: once as an instruction fetch, once by the LDR.
    vectorsApplied++; if (ld7Cycles0 !== 6) begin miscompares++; $display("[TB] FAIL addr7_read_cycles: got %0d want 6", ld7Cycles0); end
    vectorsApplied++; if (dut0.regs_q[2] !== 16'h1234) begin miscompares++; $display("[TB] FAIL ldr_r2: got %h want 1234", dut0.regs_q[2]); end
    vectorsApplied++; if (badWdata0 !== 0) begin miscompares++; $display("[TB] FAIL wdata_idle: got %0d nonzero cycles want 0", badWdata0); end
    waitStates0 = 0;
  endtask

  task automatic test_bl_bx;
    int cycles;
    logic [8:0] expLog [8];
    expLog = '{9'd0, 9'd10, 9'd13, 9'd11, 9'd12, 9'd20, 9'd13, 9'd21};
    clearImage0();
    image0[0]  = bcond(3'b000, 8'd9);
    image0[10] = {3'b010, 2'b11, 3'b111, 8'd2};
    image0[11] = movi(3'd6, 8'd20);
    image0[12] = bxop(2'b10, 3'd6);
    image0[13] = bxop(2'b00, 3'd7);
    image0[20] = bxop(2'b10, 3'd7);
    image0[21] = HALT;
    doReset0();
    runUntilHalt(0, 100, cycles);
    vectorsApplied++; if (readLog0.size() !== 8) begin miscompares++; $display("[TB] FAIL fetch_count: got %0d want 8", readLog0.size()); end
    for (int i = 0; i < 8; i++) begin
      vectorsApplied++;
      if (i >= readLog0.size() || readLog0[i] !== expLog[i]) begin
        miscompares++;
        $display("[TB] FAIL fetch_seq[%0d]: got %0d want %0d", i, (i < readLog0.size()) ? readLog0[i] : 9'h1FF, expLog[i]);
      end
    end
    vectorsApplied++; if (dut0.regs_q[7] !== 16'd21) begin miscompares++; $display("[TB] FAIL link_r7: got %0d want 21", dut0.regs_q[7]); end
  endtask

  task automatic test_wrap_wide;
    int cycles;
    foreach (image1[i]) image1[i] = 32'h0;
    image1[13] = {16'hA5A5, movi(3'd0, 8'hFF)};
    image1[14] = {16'hA5A5, movr(3'd0, 2'b10, 3'd0)};
    image1[15] = {16'hA5A5, bcond(3'b000, 8'd0)};
    image1[0]  = {16'hA5A5, HALT};
    @(negedge clk); reset1 = 1'b1;
    repeat (2) @(negedge clk); reset1 = 1'b0;
    runUntilHalt(1, 50, cycles);
    vectorsApplied++; if (halted1 !== 1'b1) begin miscompares++; $display("[TB] FAIL wide_halt: got %b want 1", halted1); end
    vectorsApplied++; if (readLog1.size() !== 4 || readLog1[3] !== 4'd0) begin miscompares++; $display("[TB] FAIL pc_wrap: got %0d fetches, last %0d want 4, 0", readLog1.size(), readLog1[readLog1.size()-1]); end
    vectorsApplied++; if (dut1.regs_q[0] !== 32'h7FFFFFFF) begin miscompares++; $display("[TB] FAIL lsr_wide: got %h want 7fffffff", dut1.regs_q[0]); end
  endtask

  task automatic test_reset_in_mem;
    int waited;
    clearImage0();
    waitStates0 = 1; stallWrites0 = 1'b1;
    image0[0] = movi(3'd1, 8'd4);
    image0[1] = {3'b100, 2'b00, 3'd1, 3'd0, 5'd3};
    image0[2] = HALT;
    doReset0();
    waited = 0;
    while (bus0.mem_cmd !== 2'b10 && waited < 40) begin @(posedge clk); #1; waited++; end
    vectorsApplied++; if (bus0.mem_cmd !== 2'b10 || bus0.mem_addr !== 9'd7) begin miscompares++; $display("[TB] FAIL str_issue: got cmd %b addr %0d want 10/7", bus0.mem_cmd, bus0.mem_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset0 = 1'b1;
    @(posedge clk); #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b00 || bus0.mem_addr !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_abort: got cmd %b addr %0d want 00/0", bus0.mem_cmd, bus0.mem_addr); end
    vectorsApplied++; if (writes0 !== 0) begin miscompares++; $display("[TB] FAIL abort_no_write: got %0d writes want 0", writes0); end
    @(negedge clk); reset0 = 1'b0; stallWrites0 = 1'b0; waitStates0 = 0;
    @(posedge clk); #1;
    vectorsApplied++; if (bus0.mem_cmd !== 2'b01 || bus0.mem_addr !== 9'd0) begin miscompares++; $display("[TB] FAIL refetch: got cmd %b addr %0d want 01/0", bus0.mem_cmd, bus0.mem_addr); end
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1; clear0 = 1'b1;
    stallWrites0 = 1'b0; waitStates0 = 0;
    clearImage0();
    foreach (image1[i]) image1[i] = 32'h0;
    test_reset();
    test_alu_program();
    test_branch_lt();
    test_cond_logic();
    test_mem_waits();
    test_bl_bx();
    test_wrap_wide();
    test_reset_in_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end
endmodule
